// File: rtl/sketch_pkg.sv
// Shared types and constants for the sketch merge job controller.
package sketch_pkg;

    localparam int unsigned SKETCH_REG_W = 4;
    localparam int unsigned SKETCH_REGS  = 32;
    localparam int unsigned SKETCH_ROW_W = SKETCH_REG_W * SKETCH_REGS;

    typedef logic [SKETCH_ROW_W-1:0] row_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } sched_state_t;

endpackage

// File: rtl/sketch_credit_cnt.sv
// Up/down credit counter with reload-to-full, saturation at full and an overflow flag.
module sketch_credit_cnt #(
    parameter int unsigned CREDITS  = 16,
    parameter int unsigned CNT_BITS = $clog2(CREDITS + 1)
) (
    input  logic                aclk,
    input  logic                aresetn,
    input  logic                reload,
    input  logic                inc,
    input  logic                dec,
    output logic [CNT_BITS-1:0] count,
    output logic                overflow
);

    localparam logic [CNT_BITS-1:0] FULL = CNT_BITS'(CREDITS);

    logic [CNT_BITS-1:0] count_q, count_d;

    always_comb begin
        count_d  = count_q;
        overflow = 1'b0;
        if (reload) begin
            count_d = FULL;
        end else if (inc && !dec) begin
            // A return with nothing outstanding: hold at full and flag it.
            if (count_q == FULL) begin
                overflow = 1'b1;
            end else begin
                count_d = count_q + 1'b1;
            end
        end else if (dec && !inc) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            count_q <= FULL;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/sketch_merge_sched.sv
// Pairs rows from two AXI-Stream sources into the no-backpressure merge pipeline,
// bounding rows in flight by result FIFO credits and sequencing a num_rows job.
module sketch_merge_sched
    import sketch_pkg::*;
#(
    parameter int unsigned DATA_W  = 128,
    parameter int unsigned CNT_W   = 32,
    parameter int unsigned CREDITS = 16
) (
    input  logic              aclk,
    input  logic              aresetn,
    input  logic              start,
    input  logic [CNT_W-1:0]  num_rows,
    output logic              busy,
    output logic              done,
    output logic [1:0]        err,
    output logic [CNT_W-1:0]  rows_issued,
    input  logic [DATA_W-1:0] s_a_tdata,
    input  logic              s_a_tvalid,
    output logic              s_a_tready,
    input  logic [DATA_W-1:0] s_b_tdata,
    input  logic              s_b_tvalid,
    output logic              s_b_tready,
    output logic [DATA_W-1:0] mrg_a1,
    output logic [DATA_W-1:0] mrg_a2,
    output logic              mrg_valid,
    input  logic              res_fire
);

    localparam int unsigned         CRED_W    = $clog2(CREDITS + 1);
    localparam logic [CRED_W-1:0]   CRED_FULL = CRED_W'(CREDITS);

    sched_state_t      state_q, state_d;
    logic [CNT_W-1:0]  remaining_q, remaining_d;
    logic [CNT_W-1:0]  rows_q, rows_d;
    logic [1:0]        err_q, err_d;
    logic [CRED_W-1:0] credits;
    logic              cred_ovf;
    logic              start_ok;
    logic              issue;
    logic              mv_q;
    logic [DATA_W-1:0] a1_q, a2_q;

    assign start_ok = start && (state_q == IDLE);

    // res_fire only reaches the credit register, so ready never depends on it combinationally.
    assign issue = (state_q == RUN) && s_a_tvalid && s_b_tvalid &&
                   (credits != '0) && (remaining_q != '0);

    sketch_credit_cnt #(
        .CREDITS  (CREDITS),
        .CNT_BITS (CRED_W)
    ) u_credit_cnt (
        .aclk     (aclk),
        .aresetn  (aresetn),
        .reload   (start_ok),
        .inc      (res_fire && (state_q != IDLE)),
        .dec      (issue),
        .count    (credits),
        .overflow (cred_ovf)
    );

    always_comb begin
        state_d     = state_q;
        remaining_d = remaining_q;
        rows_d      = rows_q;
        err_d       = start_ok ? 2'b00 : err_q;
        if (cred_ovf) begin
            err_d[0] = 1'b1;
        end
        if (res_fire && (state_q == IDLE)) begin
            err_d[1] = 1'b1;
        end

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    remaining_d = num_rows;
                    rows_d      = '0;
                    state_d     = (num_rows != '0) ? RUN : DRAIN;
                end
            end
            RUN: begin
                if (issue) begin
                    remaining_d = remaining_q - 1'b1;
                    rows_d      = rows_q + 1'b1;
                    if (remaining_q == CNT_W'(1)) begin
                        state_d = DRAIN;
                    end
                end
            end
            DRAIN: begin
                if (credits == CRED_FULL) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_q     <= IDLE;
            remaining_q <= '0;
            rows_q      <= '0;
            err_q       <= 2'b00;
        end else begin
            state_q     <= state_d;
            remaining_q <= remaining_d;
            rows_q      <= rows_d;
            err_q       <= err_d;
        end
    end

    // Merge beat is registered; data holds between beats.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            mv_q <= 1'b0;
            a1_q <= '0;
            a2_q <= '0;
        end else begin
            mv_q <= issue;
            if (issue) begin
                a1_q <= s_a_tdata;
                a2_q <= s_b_tdata;
            end
        end
    end

    assign s_a_tready  = issue;
    assign s_b_tready  = issue;
    assign mrg_valid   = mv_q;
    assign mrg_a1      = a1_q;
    assign mrg_a2      = a2_q;
    assign busy        = (state_q == RUN) || (state_q == DRAIN);
    assign done        = (state_q == DONE);
    assign err         = err_q;
    assign rows_issued = rows_q;

endmodule

// File: tb/tb_sketch_merge_sched.sv
// Directed and randomized bench for sketch_merge_sched against a cycle-level job model.
module tb_sketch_merge_sched;

    localparam int CREDITS = 16;

    logic         aclk = 1'b0;
    logic         aresetn = 1'b0;
    logic         start = 1'b0;
    logic [31:0]  num_rows = '0;
    logic         busy, done, mrg_valid, s_a_tready, s_b_tready;
    logic [1:0]   err;
    logic [31:0]  rows_issued;
    logic [127:0] s_a_tdata = '0, s_b_tdata = '0, mrg_a1, mrg_a2;
    logic         s_a_tvalid = 1'b0, s_b_tvalid = 1'b0;
    logic         res_fire = 1'b0;

    sketch_merge_sched #(
        .DATA_W  (128),
        .CNT_W   (32),
        .CREDITS (CREDITS)
    ) dut (
        .aclk        (aclk),
        .aresetn     (aresetn),
        .start       (start),
        .num_rows    (num_rows),
        .busy        (busy),
        .done        (done),
        .err         (err),
        .rows_issued (rows_issued),
        .s_a_tdata   (s_a_tdata),
        .s_a_tvalid  (s_a_tvalid),
        .s_a_tready  (s_a_tready),
        .s_b_tdata   (s_b_tdata),
        .s_b_tvalid  (s_b_tvalid),
        .s_b_tready  (s_b_tready),
        .mrg_a1      (mrg_a1),
        .mrg_a2      (mrg_a2),
        .mrg_valid   (mrg_valid),
        .res_fire    (res_fire)
    );

    always #5 aclk = ~aclk;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;

    // Job model: phase 0 idle, 1 issuing, 2 waiting for results, 3 finished
    int           ms = 0, mrem = 0, mrows = 0, mcred = CREDITS;
    logic [1:0]   merr = 2'b00;
    logic         mmv = 1'b0;
    logic [127:0] ma1 = '0, ma2 = '0;

    // Stimulus controls
    logic [127:0] qa[$], qb[$];
    int           due[$];
    int           outstanding = 0;
    logic         a_on = 1'b1, b_on = 1'b1, a_keep = 1'b0, b_keep = 1'b0, force_res = 1'b0;
    int           a_from = 0, b_from = 0, cap = 1000000, drop = 0, res_delay = 25;

    function automatic logic [127:0] rand_row();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic model_reset();
        ms = 0; mrem = 0; mrows = 0; mcred = CREDITS; merr = 2'b00;
        mmv = 1'b0; ma1 = '0; ma2 = '0;
        due.delete(); outstanding = 0; a_keep = 1'b0; b_keep = 1'b0;
    endtask

    // One clock cycle: drive inputs, check at negedge, advance the model.
    task automatic step();
        logic iss;
        int   old_ms, nc;
        if (!a_keep)
            s_a_tvalid = a_on && cyc >= a_from && mrows < cap &&
                         (drop == 0 || int'($urandom_range(0, 99)) >= drop);
        if (!b_keep)
            s_b_tvalid = b_on && cyc >= b_from && mrows < cap &&
                         (drop == 0 || int'($urandom_range(0, 99)) >= drop);
        s_a_tdata = (qa.size() > 0) ? qa[0] : '0;
        s_b_tdata = (qb.size() > 0) ? qb[0] : '0;
        res_fire = force_res;
        if (due.size() > 0 && due[0] <= cyc) begin
            res_fire = 1'b1;
            void'(due.pop_front());
        end

        @(negedge aclk);
        iss = (ms == 1) && s_a_tvalid && s_b_tvalid && mcred > 0 && mrem > 0;
        chk("ready_a", s_a_tready, iss);
        chk("ready_b", s_b_tready, iss);
        chk("mrg_valid", mrg_valid, mmv);
        chk("mrg_a1", mrg_a1, ma1);
        chk("mrg_a2", mrg_a2, ma2);
        chk("busy", busy, (ms == 1 || ms == 2));
        chk("done", done, ms == 3);
        chk("err", err, merr);
        chk("rows_issued", rows_issued, 32'(mrows));

        old_ms = ms;
        if (old_ms == 0 && start) merr = 2'b00;
        if (old_ms == 0 && res_fire) merr[1] = 1'b1;
        case (old_ms)
            0: if (start) begin
                mrem = int'(num_rows); mrows = 0; ms = (num_rows != 0) ? 1 : 2;
            end
            1: if (iss) begin
                mrem--; mrows++;
                if (mrem == 0) ms = 2;
            end
            2: if (mcred == CREDITS) ms = 3;
            default: ms = 0;
        endcase
        if (old_ms == 0) begin
            if (start) mcred = CREDITS;
        end else begin
            nc = mcred + (res_fire ? 1 : 0) - (iss ? 1 : 0);
            if (nc > CREDITS) begin
                nc = CREDITS;
                merr[0] = 1'b1;
            end
            mcred = nc;
        end
        mmv = iss;
        if (iss) begin
            ma1 = qa.pop_front();
            ma2 = qb.pop_front();
            outstanding++;
            if (res_delay >= 0) due.push_back(cyc + res_delay);
        end
        if (res_fire && outstanding > 0) outstanding--;
        a_keep = s_a_tvalid && !iss;
        b_keep = s_b_tvalid && !iss;

        @(posedge aclk);
        #1;
        cyc++;
    endtask

    task automatic start_job(input int n);
        qa.delete(); qb.delete(); a_keep = 1'b0; b_keep = 1'b0;
        for (int i = 0; i < n + 8; i++) begin
            qa.push_back(rand_row());
            qb.push_back(rand_row());
        end
        num_rows = 32'(n);
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic run_idle(input int limit);
        int n = 0;
        while (ms != 0 && n < limit) begin
            step();
            n++;
        end
        assert (n < limit)
        else begin
            n_bad++;
            $error("FAIL job_budget: observed %0d cycles required under %0d", n, limit);
        end
        chk("job_end_busy", busy, 1'b0);
    endtask

    task automatic run_until_rows(input int r, input int limit);
        int n = 0;
        while (mrows < r && n < limit) begin
            step();
            n++;
        end
        assert (n < limit)
        else begin
            n_bad++;
            $error("FAIL rows_budget: observed %0d rows required %0d", mrows, r);
        end
    endtask

    task automatic pulse_res(input int n);
        for (int i = 0; i < n; i++) begin
            force_res = 1'b1;
            step();
            force_res = 1'b0;
            step();
        end
    endtask

    initial begin
        // Reset values
        #2;
        chk("rst_busy", busy, 1'b0);
        chk("rst_mrg_valid", mrg_valid, 1'b0);
        chk("rst_err", err, 2'b00);
        chk("rst_rows", rows_issued, 32'd0);
        chk("rst_a1", mrg_a1, 128'd0);
        @(posedge aclk);
        #1;
        aresetn = 1'b1;
        step();
        step();

        // Basic job
        res_delay = 25;
        start_job(4);
        run_idle(200);
        chk("basic_rows", rows_issued, 32'd4);

        // Credit stall, then return credits one at a time
        res_delay = -1;
        start_job(20);
        for (int i = 0; i < 30; i++) step();
        chk("stall_rows", rows_issued, 32'd16);
        chk("stall_busy", busy, 1'b1);
        pulse_res(4);
        step();
        chk("stall_rows_after", rows_issued, 32'd20);
        pulse_res(outstanding);
        run_idle(50);

        // Stream skew: B arrives 5 cycles after A
        res_delay = 2;
        a_from = cyc; b_from = cyc + 5;
        start_job(3);
        run_idle(100);
        a_from = 0; b_from = 0;

        // Issue and return together at one credit
        res_delay = -1;
        cap = 15;
        start_job(18);
        for (int i = 0; i < 22; i++) step();
        cap = 1000000;
        force_res = 1'b1;
        step();
        force_res = 1'b0;
        step();
        step();
        chk("one_credit_rows", rows_issued, 32'd17);
        pulse_res(outstanding);
        step();
        pulse_res(outstanding);
        run_idle(60);

        // Zero-row job
        start_job(0);
        run_idle(10);

        // start during RUN is ignored
        res_delay = 5;
        start_job(6);
        step();
        num_rows = 32'd99;
        start = 1'b1;
        step();
        start = 1'b0;
        run_idle(100);
        chk("restart_ignored_rows", rows_issued, 32'd6);

        // res_fire in IDLE, cleared by next start
        force_res = 1'b1;
        step();
        force_res = 1'b0;
        step();
        chk("idle_fire_err", err, 2'b10);

        // Credit overflow while no row is in flight
        a_on = 1'b0;
        start_job(3);
        force_res = 1'b1;
        step();
        force_res = 1'b0;
        step();
        a_on = 1'b1;
        run_idle(100);
        chk("overflow_err", err, 2'b01);

        // Reset mid-job
        res_delay = -1;
        start_job(8);
        run_until_rows(3, 40);
        aresetn = 1'b0;
        #1;
        chk("arst_mrg_valid", mrg_valid, 1'b0);
        chk("arst_busy", busy, 1'b0);
        chk("arst_ready_a", s_a_tready, 1'b0);
        chk("arst_ready_b", s_b_tready, 1'b0);
        chk("arst_rows", rows_issued, 32'd0);
        model_reset();
        @(posedge aclk);
        #1;
        aresetn = 1'b1;
        cyc++;
        step();
        res_delay = 4;
        start_job(2);
        run_idle(60);

        // Randomized jobs
        for (int j = 0; j < 8; j++) begin
            drop = int'($urandom_range(0, 50));
            res_delay = int'($urandom_range(0, 30));
            start_job(int'($urandom_range(1, 30)));
            run_idle(3000);
            step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
